// File: rtl/speed_gate_meter.sv
// Two-gate speed meter: times the transit between gates A and B, divides the gate spacing by the
// transit time to get cm/s, converts the result to BCD and drives a blanked seven-segment display.
module speed_gate_meter #(
  parameter int unsigned CLK_HZ      = 12_000_000,
  parameter int unsigned DIST_CM     = 30,
  parameter int unsigned TIMEOUT_CYC = 24_000_000,
  parameter int unsigned DIGITS      = 4,
  parameter bit          BLANK_LZ    = 1'b1,
  localparam int unsigned MAXV       = 10**DIGITS - 1,
  localparam int unsigned SPEED_W    = $clog2(MAXV + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sensor_a,
  input  logic                  sensor_b,
  output logic [7*DIGITS-1:0]   seg,
  output logic [SPEED_W-1:0]    speed,
  output logic                  dir,
  output logic                  valid,
  output logic                  busy,
  output logic                  timeout,
  output logic                  ovf
);

  localparam longint unsigned NUM   = 64'(CLK_HZ) * 64'(DIST_CM);
  localparam int unsigned     NUM_W = $clog2(NUM + 1);
  localparam int unsigned     CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned     DW    = (NUM_W > CNT_W) ? NUM_W : CNT_W;
  localparam int unsigned     BW    = 4 * DIGITS;
  localparam int unsigned     IW    = $clog2(((NUM_W > SPEED_W) ? NUM_W : SPEED_W) + 1);

  typedef enum logic [2:0] {StIdle, StTiming, StDivide, StConvert, StUpdate} state_e;

  state_e             state_q;
  logic [1:0]         sync_a_q, sync_b_q;
  logic               a_d_q, b_d_q, rise_a_q, rise_b_q;
  logic               start_b_q, dir_n_q, ovf_n_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DW-1:0]      rem_q;
  logic [NUM_W-1:0]   num_q, quo_q;
  logic [IW-1:0]      step_q;
  logic [SPEED_W-1:0] bin_q, sat_q;
  logic [BW-1:0]      bcd_q, digits_q;

  logic               start_rise, stop_rise;
  logic [DW:0]        rem_shift, div_ext;
  logic               ge;
  logic [DW-1:0]      rem_next;
  logic [NUM_W-1:0]   quo_next;
  logic               q_over;
  logic [SPEED_W-1:0] q_sat;
  logic [BW-1:0]      bcd_adj, bcd_next;

  // Input path: 2-FF synchroniser, then a registered rise detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
      a_d_q    <= 1'b0;
      b_d_q    <= 1'b0;
      rise_a_q <= 1'b0;
      rise_b_q <= 1'b0;
    end else begin
      sync_a_q <= {sync_a_q[0], sensor_a};
      sync_b_q <= {sync_b_q[0], sensor_b};
      a_d_q    <= sync_a_q[1];
      b_d_q    <= sync_b_q[1];
      rise_a_q <= sync_a_q[1] & ~a_d_q;
      rise_b_q <= sync_b_q[1] & ~b_d_q;
    end
  end

  always_comb begin
    start_rise = start_b_q ? rise_b_q : rise_a_q;
    stop_rise  = start_b_q ? rise_a_q : rise_b_q;

    // One restoring-division step; the transit count stays frozen in cnt_q as the divisor.
    rem_shift = {rem_q, num_q[NUM_W-1]};
    div_ext   = (DW + 1)'(cnt_q);
    ge        = (rem_shift >= div_ext);
    rem_next  = ge ? DW'(rem_shift - div_ext) : DW'(rem_shift);
    quo_next  = (quo_q << 1) | NUM_W'(ge);
    q_over    = (64'(quo_next) > 64'(MAXV));
    q_sat     = q_over ? SPEED_W'(MAXV) : SPEED_W'(quo_next);

    // One double-dabble step: add 3 to digits >= 5, then shift in the next binary bit.
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_next = (bcd_adj << 1) | BW'(bin_q[SPEED_W-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      start_b_q <= 1'b0;
      dir_n_q   <= 1'b0;
      ovf_n_q   <= 1'b0;
      cnt_q     <= '0;
      rem_q     <= '0;
      num_q     <= '0;
      quo_q     <= '0;
      step_q    <= '0;
      bin_q     <= '0;
      sat_q     <= '0;
      bcd_q     <= '0;
      digits_q  <= '0;
      speed     <= '0;
      dir       <= 1'b0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          valid <= 1'b0;
          if (rise_a_q != rise_b_q) begin
            start_b_q <= rise_b_q;
            dir_n_q   <= rise_b_q;
            cnt_q     <= CNT_W'(1);
            timeout   <= 1'b0;
            state_q   <= StTiming;
          end
        end
        StTiming: begin
          if (stop_rise) begin
            rem_q   <= '0;
            num_q   <= NUM_W'(NUM);
            quo_q   <= '0;
            step_q  <= '0;
            state_q <= StDivide;
          end else if (start_rise) begin
            cnt_q <= CNT_W'(1);
          end else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
            timeout <= 1'b1;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StDivide: begin
          rem_q  <= rem_next;
          num_q  <= num_q << 1;
          quo_q  <= quo_next;
          step_q <= step_q + IW'(1);
          if (step_q == IW'(NUM_W - 1)) begin
            ovf_n_q <= q_over;
            sat_q   <= q_sat;
            bin_q   <= q_sat;
            bcd_q   <= '0;
            step_q  <= '0;
            state_q <= StConvert;
          end
        end
        StConvert: begin
          bin_q  <= bin_q << 1;
          bcd_q  <= bcd_next;
          step_q <= step_q + IW'(1);
          // Results land on the transition so they are visible throughout the UPDATE cycle.
          if (step_q == IW'(SPEED_W - 1)) begin
            digits_q <= bcd_next;
            speed    <= sat_q;
            dir      <= dir_n_q;
            ovf      <= ovf_n_q;
            valid    <= 1'b1;
            state_q  <= StUpdate;
          end
        end
        StUpdate: begin
          valid   <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q == StTiming) || (state_q == StDivide) || (state_q == StConvert);

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 7'h3F;
      4'd1:    seg_enc = 7'h06;
      4'd2:    seg_enc = 7'h5B;
      4'd3:    seg_enc = 7'h4F;
      4'd4:    seg_enc = 7'h66;
      4'd5:    seg_enc = 7'h6D;
      4'd6:    seg_enc = 7'h7D;
      4'd7:    seg_enc = 7'h07;
      4'd8:    seg_enc = 7'h7F;
      4'd9:    seg_enc = 7'h6F;
      default: seg_enc = 7'h00;
    endcase
  endfunction

  logic lead;

  // Walk from the most significant digit; lead stays set while everything above is zero.
  always_comb begin
    lead = 1'b1;
    seg  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (BLANK_LZ && (i > 0) && lead && (digits_q[4*i +: 4] == 4'd0)) begin
        seg[7*i +: 7] = 7'h00;
      end else begin
        seg[7*i +: 7] = seg_enc(digits_q[4*i +: 4]);
      end
      if (digits_q[4*i +: 4] != 4'd0) lead = 1'b0;
    end
  end

endmodule

// File: tb/tb_speed_gate_meter.sv
// Directed bench for speed_gate_meter with a scaled-down clock so transits stay short.
module tb_speed_gate_meter;

  // NUM = 30000 -> NUM_W = 15; SPEED_W = 14; valid comes 3 + 15 + 14 + 1 = 33 edges after the pin.
  localparam int unsigned ClkHz   = 1000;
  localparam int unsigned DistCm  = 30;
  localparam int unsigned Timeout = 2000;
  localparam int          LatExp  = 33;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sensor_a = 1'b0;
  logic        sensor_b = 1'b0;
  logic [27:0] seg;
  logic [13:0] speed;
  logic        dir, valid, busy, timeout, ovf;

  int checks   = 0;
  int failures = 0;
  int vcount   = 0;
  int lat;
  int vbefore;

  speed_gate_meter #(
    .CLK_HZ     (ClkHz),
    .DIST_CM    (DistCm),
    .TIMEOUT_CYC(Timeout),
    .DIGITS     (4),
    .BLANK_LZ   (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sensor_a(sensor_a),
    .sensor_b(sensor_b),
    .seg     (seg),
    .speed   (speed),
    .dir     (dir),
    .valid   (valid),
    .busy    (busy),
    .timeout (timeout),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (valid === 1'b1) vcount++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Counts edges from the stop pin until valid is seen; drops both pins after 4 cycles.
  task automatic wait_valid(output int l);
    l = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i == 4) begin
        sensor_a = 1'b0;
        sensor_b = 1'b0;
      end
      if (valid === 1'b1) begin
        l = i;
        break;
      end
    end
  endtask

  task automatic measure(input bit a_first, input int gap, output int l);
    @(negedge clk);
    if (a_first) sensor_a = 1'b1; else sensor_b = 1'b1;
    repeat (gap) @(negedge clk);
    if (a_first) sensor_b = 1'b1; else sensor_a = 1'b1;
    wait_valid(l);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_speed", 64'(speed), 64'd0);
    check("rst_dir", 64'(dir), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_seg", 64'(seg), 64'h000_003F);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // A then B, 1000 cycles -> 30000/1000 = 30
    measure(1'b1, 1000, lat);
    check("ab30_lat", 64'(lat), 64'(LatExp));
    check("ab30_speed", 64'(speed), 64'd30);
    check("ab30_dir", 64'(dir), 64'd0);
    check("ab30_ovf", 64'(ovf), 64'd0);
    check("ab30_seg", 64'(seg), 64'({7'h00, 7'h00, 7'h4F, 7'h3F}));
    @(negedge clk);
    check("ab30_pulse", 64'(valid), 64'd0);
    repeat (3) @(negedge clk);

    // B then A, 300 cycles -> 100
    measure(1'b0, 300, lat);
    check("ba100_lat", 64'(lat), 64'(LatExp));
    check("ba100_speed", 64'(speed), 64'd100);
    check("ba100_dir", 64'(dir), 64'd1);
    check("ba100_seg", 64'(seg), 64'({7'h00, 7'h06, 7'h3F, 7'h3F}));
    repeat (4) @(negedge clk);

    // A then B, 3 cycles -> 10000, saturates
    measure(1'b1, 3, lat);
    check("ovf_lat", 64'(lat), 64'(LatExp));
    check("ovf_speed", 64'(speed), 64'd9999);
    check("ovf_flag", 64'(ovf), 64'd1);
    check("ovf_dir", 64'(dir), 64'd0);
    check("ovf_seg", 64'(seg), 64'({7'h6F, 7'h6F, 7'h6F, 7'h6F}));
    repeat (4) @(negedge clk);

    // A only: timeout fires once cnt reaches 2000 (2004 edges after the pin)
    vbefore = vcount;
    @(negedge clk);
    sensor_a = 1'b1;
    repeat (4) @(negedge clk);
    sensor_a = 1'b0;
    repeat (1999) @(negedge clk);
    check("to_before", 64'(timeout), 64'd0);
    check("to_busy_before", 64'(busy), 64'd1);
    @(negedge clk);
    check("to_flag", 64'(timeout), 64'd1);
    check("to_busy", 64'(busy), 64'd0);
    check("to_speed_hold", 64'(speed), 64'd9999);
    check("to_ovf_hold", 64'(ovf), 64'd1);
    check("to_seg_hold", 64'(seg), 64'({7'h6F, 7'h6F, 7'h6F, 7'h6F}));
    check("to_no_valid", 64'(vcount - vbefore), 64'd0);
    repeat (4) @(negedge clk);

    // Retrigger: A, A again at +500, B 100 later -> 30000/100 = 300
    @(negedge clk);
    sensor_a = 1'b1;
    repeat (4) @(negedge clk);
    sensor_a = 1'b0;
    repeat (496) @(negedge clk);
    check("rt_to_cleared", 64'(timeout), 64'd0);
    sensor_a = 1'b1;
    repeat (100) @(negedge clk);
    sensor_b = 1'b1;
    wait_valid(lat);
    check("rt_lat", 64'(lat), 64'(LatExp));
    check("rt_speed", 64'(speed), 64'd300);
    check("rt_ovf", 64'(ovf), 64'd0);
    check("rt_seg", 64'(seg), 64'({7'h00, 7'h4F, 7'h3F, 7'h3F}));
    repeat (4) @(negedge clk);

    // Simultaneous rises in IDLE must not start a measurement
    vbefore = vcount;
    @(negedge clk);
    sensor_a = 1'b1;
    sensor_b = 1'b1;
    repeat (4) @(negedge clk);
    sensor_a = 1'b0;
    sensor_b = 1'b0;
    repeat (2) @(negedge clk);
    check("both_busy", 64'(busy), 64'd0);
    repeat (50) @(negedge clk);
    check("both_no_valid", 64'(vcount - vbefore), 64'd0);
    check("both_speed", 64'(speed), 64'd300);

    // Reset while dividing
    @(negedge clk);
    sensor_a = 1'b1;
    repeat (1000) @(negedge clk);
    sensor_b = 1'b1;
    repeat (8) @(negedge clk);
    check("rd_busy_div", 64'(busy), 64'd1);
    sensor_a = 1'b0;
    sensor_b = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rd_busy", 64'(busy), 64'd0);
    check("rd_speed", 64'(speed), 64'd0);
    check("rd_seg", 64'(seg), 64'h000_003F);
    repeat (60) @(negedge clk);
    check("rd_no_valid", 64'(valid), 64'd0);

    // A fresh measurement after the reset, B first
    measure(1'b0, 1000, lat);
    check("post_lat", 64'(lat), 64'(LatExp));
    check("post_speed", 64'(speed), 64'd30);
    check("post_dir", 64'(dir), 64'd1);
    check("post_seg", 64'(seg), 64'({7'h00, 7'h00, 7'h4F, 7'h3F}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
